// File: rtl/mem_access_stage.sv
// Memory access stage: runs a req/ack transaction against variable-latency data
// memory, stalls upstream while it is in flight, and fills the MEM/WB register.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RESULT     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] alu_result,
    input  logic [31:0] data2,
    input  logic [31:0] inst,
    input  logic [3:0]  rd,
    input  logic        rwrite,
    input  logic        select_mem,
    input  logic        we,
    input  logic        data_input_s,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        stall,
    output logic        mem_err,
    output logic [31:0] wb_result,
    output logic [31:0] wb_inst,
    output logic [3:0]  wb_rd,
    output logic        wb_rwrite,
    output logic        wb_valid
);

    // state  | meaning
    // IDLE   | no transaction; a memory op moves to REQ
    // REQ    | mem_req asserted, waiting for mem_ack or timeout
    // DONE   | result ready, stall released, MEM/WB written
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        abort_q, abort_d;
    logic        err_q, err_d;
    logic [31:0] wb_result_q, wb_result_d;
    logic [31:0] wb_inst_q, wb_inst_d;
    logic [3:0]  wb_rd_q, wb_rd_d;
    logic        wb_rwrite_q, wb_rwrite_d;
    logic        wb_valid_q, wb_valid_d;
    logic [7:0]  load_byte;
    logic [31:0] load_data;
    logic        in_req;

    assign in_req    = (state_q == S_REQ);
    assign stall     = select_mem && (state_q != S_DONE);
    assign mem_req   = in_req;
    assign mem_we    = in_req && we;
    assign mem_addr  = {alu_result[31:2], 2'b00};
    assign mem_wdata = data_input_s ? {4{data2[7:0]}} : data2;
    assign mem_be    = !in_req      ? 4'b0000 :
                       data_input_s ? (4'b0001 << alu_result[1:0]) : 4'b1111;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                cnt_d   = 8'd0;
                abort_d = 1'b0;
                if (select_mem) state_d = S_REQ;
            end
            S_REQ: begin
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    cnt_d   = 8'd0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (alu_result[1:0])
            2'd0:    load_byte = rdata_q[7:0];
            2'd1:    load_byte = rdata_q[15:8];
            2'd2:    load_byte = rdata_q[23:16];
            default: load_byte = rdata_q[31:24];
        endcase
        load_data = data_input_s ? {24'h0, load_byte} : rdata_q;
    end

    // A stalled cycle inserts a bubble; result fields keep their last value.
    always_comb begin
        wb_valid_d  = 1'b0;
        wb_rwrite_d = 1'b0;
        wb_result_d = wb_result_q;
        wb_inst_d   = wb_inst_q;
        wb_rd_d     = wb_rd_q;
        if (!stall) begin
            wb_valid_d  = 1'b1;
            wb_inst_d   = inst;
            wb_rd_d     = rd;
            wb_rwrite_d = rwrite && !(select_mem && abort_q);
            if (select_mem && !we)
                wb_result_d = abort_q ? ERR_RESULT : load_data;
            else
                wb_result_d = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            rdata_q     <= 32'h0;
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
            wb_result_q <= 32'h0;
            wb_inst_q   <= 32'h0;
            wb_rd_q     <= 4'h0;
            wb_rwrite_q <= 1'b0;
            wb_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rdata_q     <= rdata_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
            wb_result_q <= wb_result_d;
            wb_inst_q   <= wb_inst_d;
            wb_rd_q     <= wb_rd_d;
            wb_rwrite_q <= wb_rwrite_d;
            wb_valid_q  <= wb_valid_d;
        end
    end

    assign mem_err   = err_q;
    assign wb_result = wb_result_q;
    assign wb_inst   = wb_inst_q;
    assign wb_rd     = wb_rd_q;
    assign wb_rwrite = wb_rwrite_q;
    assign wb_valid  = wb_valid_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed scenarios plus random ops checked against
// a transaction-level model with a word-array memory.
module tb_mem_access_stage;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_result, data2, inst, mem_rdata;
    logic [3:0]  rd;
    logic        rwrite, select_mem, we, data_input_s, mem_ack;
    logic        mem_req, mem_we, stall, mem_err, wb_rwrite, wb_valid;
    logic [31:0] mem_addr, mem_wdata, wb_result, wb_inst;
    logic [3:0]  mem_be, wb_rd;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_arr [0:15];
    bit          err_model;

    mem_access_stage #(.TIMEOUT_CYCLES(TMO), .ERR_RESULT(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .alu_result(alu_result), .data2(data2), .inst(inst),
        .rd(rd), .rwrite(rwrite), .select_mem(select_mem), .we(we),
        .data_input_s(data_input_s), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .stall(stall), .mem_err(mem_err), .wb_result(wb_result),
        .wb_inst(wb_inst), .wb_rd(wb_rd), .wb_rwrite(wb_rwrite), .wb_valid(wb_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction through the stage; caller is positioned at a negedge.
    // ack_wait = REQ cycles before mem_ack (>= TMO means never acknowledged).
    task automatic run_op(input bit sel, input bit wr, input bit bsz, input logic [31:0] addr,
                          input logic [31:0] d2, input int ack_wait, input logic [3:0] rdi,
                          input bit rw);
        logic [31:0] ins;
        logic [31:0] exp_res, word, exp_be, exp_wd;
        int          stalls, reqs, guard, idx, lane;
        bit          done, aborted, exp_rw;
        ins = $urandom;
        idx = int'(addr[5:2]);
        lane = int'(addr[1:0]);
        stalls = 0; reqs = 0; guard = 0; done = 0;
        alu_result = addr; data2 = d2; inst = ins; rd = rdi; rwrite = rw;
        select_mem = sel; we = wr; data_input_s = bsz;
        exp_be = bsz ? (32'h1 << lane) : 32'hF;
        exp_wd = bsz ? {4{d2[7:0]}} : d2;
        while (!done) begin
            #1;
            if (mem_req) begin
                if (reqs == 0) begin
                    check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
                    check_eq("mem_be", {28'h0, mem_be}, exp_be);
                    check_eq("mem_we", {31'h0, mem_we}, {31'h0, wr});
                    if (wr) check_eq("mem_wdata", mem_wdata, exp_wd);
                end
                if (reqs == ack_wait) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_arr[idx];
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = $urandom;
                end
                reqs++;
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            if (stalls > 0) check_eq("bubble_valid", {31'h0, wb_valid}, 32'h0);
            if (stall) stalls++;
            else done = 1;
            guard++;
            if (guard > 100) begin
                check_eq("stall_budget", 32'(guard), 32'd100);
                done = 1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        mem_ack = 1'b0;

        aborted = sel && (ack_wait >= TMO);
        exp_rw  = rw && !aborted;
        word    = mem_arr[idx];
        if (sel && !wr)
            exp_res = aborted ? 32'h0 : (bsz ? ((word >> (8 * lane)) & 32'hFF) : word);
        else
            exp_res = addr;
        if (sel && wr && !aborted) begin
            if (bsz) mem_arr[idx][8*lane +: 8] = d2[7:0];
            else     mem_arr[idx] = d2;
        end
        if (aborted) err_model = 1;

        check_eq("stall_cycles", 32'(stalls), !sel ? 32'd0 : aborted ? 32'(TMO + 1) : 32'(ack_wait + 2));
        check_eq("req_cycles", 32'(reqs), !sel ? 32'd0 : aborted ? 32'(TMO) : 32'(ack_wait + 1));
        check_eq("wb_valid", {31'h0, wb_valid}, 32'h1);
        check_eq("wb_result", wb_result, exp_res);
        check_eq("wb_inst", wb_inst, ins);
        check_eq("wb_rd", {28'h0, wb_rd}, {28'h0, rdi});
        check_eq("wb_rwrite", {31'h0, wb_rwrite}, {31'h0, exp_rw});
        check_eq("mem_err", {31'h0, mem_err}, {31'h0, err_model});
    endtask

    initial begin
        int w, k;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        err_model = 0;
        reset = 1'b1; select_mem = 1'b1; mem_ack = 1'b1; we = 1'b0; data_input_s = 1'b0;
        alu_result = 32'h0; data2 = 32'h0; inst = 32'h0; rd = 4'h0; rwrite = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check_eq("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check_eq("rst_mem_be", {28'h0, mem_be}, 32'h0);
        check_eq("rst_mem_err", {31'h0, mem_err}, 32'h0);
        check_eq("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check_eq("rst_wb_rwrite", {31'h0, wb_rwrite}, 32'h0);
        check_eq("rst_wb_result", wb_result, 32'h0);
        check_eq("rst_wb_inst", wb_inst, 32'h0);
        check_eq("rst_wb_rd", {28'h0, wb_rd}, 32'h0);
        reset = 1'b0; select_mem = 1'b0; mem_ack = 1'b0;

        run_op(0, 0, 0, 32'h1234_5678, 32'h0, 0, 4'h3, 1);
        check_eq("pass_result", wb_result, 32'h1234_5678);

        mem_arr[(32'h104 >> 2) & 15] = 32'hCAFE_F00D;
        run_op(1, 0, 0, 32'h0000_0104, 32'h0, 2, 4'h5, 1);
        check_eq("word_load", wb_result, 32'hCAFE_F00D);

        mem_arr[(32'h200 >> 2) & 15] = 32'h0000_0000;
        run_op(1, 1, 1, 32'h0000_0203, 32'h0000_00A5, 0, 4'h1, 0);
        run_op(1, 0, 1, 32'h0000_0203, 32'h0, 0, 4'h2, 1);
        check_eq("byte_load", wb_result, 32'h0000_00A5);

        run_op(1, 0, 0, 32'h0000_0040, 32'h0, 99, 4'h7, 1);
        check_eq("tmo_err", {31'h0, mem_err}, 32'h1);

        for (int n = 0; n < 150; n++) begin
            w = (($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4)));
            run_op(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom, $urandom, w, 4'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset during the second REQ cycle, with an ack arriving at the same edge.
        alu_result = 32'h0000_0080; select_mem = 1'b1; we = 1'b0; data_input_s = 1'b0;
        k = 0;
        while (!mem_req && k < 10) begin
            @(posedge clk); @(negedge clk); k++;
        end
        check_eq("rst_req_seen", {31'h0, mem_req}, 32'h1);
        @(posedge clk); @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); @(negedge clk);
        reset = 1'b0; mem_ack = 1'b0;
        err_model = 0;
        check_eq("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        check_eq("midrst_wb_valid", {31'h0, wb_valid}, 32'h0);
        check_eq("midrst_mem_err", {31'h0, mem_err}, 32'h0);
        select_mem = 1'b0;
        @(posedge clk); @(negedge clk);
        run_op(0, 0, 0, 32'hA5A5_0001, 32'h0, 0, 4'h9, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage directly downstream of the EX/MEM pipeline register.
- Consumes the registered ALU result, store data, instruction, destination register and memory controls.
- Runs a req/ack transaction with a variable-latency data memory, stalling upstream while the transaction is in flight.
- Registers the stage result into the MEM/WB register consumed by writeback.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in REQ without mem_ack before the access is aborted (range 1..255).
- ERR_RESULT, 32'h0000_0000: value placed on wb_result for an aborted load.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- alu_result  in  32  byte address for memory ops; pass-through result otherwise.
- data2  in  32  store data.
- inst  in  32  instruction word, carried to WB.
- rd  in  4  destination register index.
- rwrite  in  1  register-file write request.
- select_mem  in  1  op accesses memory.
- we  in  1  with select_mem: 1 = store, 0 = load.
- data_input_s  in  1  access size: 1 = byte, 0 = word.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  memory completes the current request.
- mem_req  out  1  request strobe.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word-aligned address: {alu_result[31:2],2'b00}.
- mem_wdata  out  32  write data.
- mem_be  out  4  byte enables.
- stall  out  1  hold EX/MEM and everything upstream (combinational).
- mem_err  out  1  sticky timeout flag.
- wb_result, wb_inst  out  32 each  MEM/WB register.
- wb_rd  out  4  MEM/WB register.
- wb_rwrite, wb_valid  out  1 each  MEM/WB register.

Behaviour:
- Reset:
  - State IDLE; timeout counter 0.
  - mem_req, mem_we, mem_be and mem_err = 0.
  - All wb_* outputs = 0.
  - Reset wins over every other event, including an in-flight request or mem_ack in the same cycle.
  - mem_req drops on the cycle after reset is sampled.
- FSM states IDLE, REQ, DONE; state, counter and captured read data are registered:
  - IDLE with select_mem=1 → REQ. IDLE with select_mem=0 stays IDLE.
  - REQ: mem_req=1, mem_we=we. If mem_ack=1, capture mem_rdata and go to DONE. Otherwise increment the counter; when the counter reaches TIMEOUT_CYCLES-1 without ack, set mem_err and go to DONE marked aborted.
  - DONE → IDLE unconditionally. The counter clears on leaving REQ.
- stall = select_mem && (state != DONE). Non-memory ops never stall.
- Latency:
  - Non-memory op: 1 cycle.
  - Memory op with mem_ack in the first REQ cycle: 3 cycles (IDLE, REQ, DONE).
  - Each extra wait cycle adds 1.
- Byte lanes:
  - Word access: mem_be = 4'b1111, mem_wdata = data2.
  - Byte access: mem_be = 1 << alu_result[1:0], mem_wdata = {4{data2[7:0]}}.
  - Word access ignores alu_result[1:0].
- Load data:
  - Word access: the captured word.
  - Byte access: the lane selected by alu_result[1:0], zero-extended to 32 bits.
- MEM/WB register, every clock edge:
  - When stall=1, insert a bubble: wb_valid=0, wb_rwrite=0; other wb_* hold their previous values.
  - Otherwise: wb_valid=1, wb_inst=inst, wb_rd=rd.
  - Non-memory op: wb_result=alu_result, wb_rwrite=rwrite.
  - Store: wb_result=alu_result, wb_rwrite=rwrite.
  - Successful load: wb_result=load data, wb_rwrite=rwrite.
  - Aborted load: wb_result=ERR_RESULT, wb_rwrite=0. An aborted store also has wb_rwrite=0.
- mem_ack outside REQ is ignored.
- Inputs are sampled while held stable by stall. Back-to-back memory ops restart in IDLE after DONE.
- mem_err stays at 1 until reset.

Test Plan:
- Reset: hold reset 2 cycles with select_mem=1 and mem_ack=1 → all outputs 0, state IDLE, no mem_req.
- ALU pass-through: alu_result=32'h1234_5678, rd=4'h3, rwrite=1, select_mem=0 → next edge wb_result=32'h1234_5678, wb_rd=3, wb_rwrite=1, wb_valid=1; stall never asserted.
- Word load with 2 wait cycles:
  - Stimulus: alu_result=32'h0000_0104, rdata 32'hCAFE_F00D, ack on the third REQ cycle.
  - Response: stall high 4 cycles; mem_addr=32'h104, mem_be=4'hF; wb_result=32'hCAFE_F00D; wb_valid low during stall.
- Byte store then byte load:
  - Store: alu_result=32'h203, data2=32'h0000_00A5, ack immediate → mem_be=4'b1000, mem_wdata=32'hA5A5_A5A5, mem_we=1.
  - Load: same address, rdata 32'hA500_0000 → wb_result=32'h0000_00A5.
- Timeout: load with mem_ack held 0, TIMEOUT_CYCLES=16 → 16 REQ cycles; then mem_err=1, wb_result=0, wb_rwrite=0, wb_valid=1; mem_err persists until reset.
- Reset mid-REQ: assert reset in the second REQ cycle alongside mem_ack=1 → next cycle IDLE, mem_req=0, no WB write, mem_err=0.
